// File: rtl/horner_pkg.sv
// Shared types and constants for the Horner polynomial sequencer.
package horner_pkg;

    localparam int FP_FRAC_W = 40;
    localparam int FP_EXP_W  = 8;

    // The most negative exponent is reserved to encode zero.
    localparam logic [FP_EXP_W-1:0] FP_ZERO_EXP = {1'b1, {(FP_EXP_W-1){1'b0}}};

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } float_t;

    localparam float_t FP_ZERO = '{sign: 1'b0, exp: FP_ZERO_EXP, frac: '0};

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_ISSUE = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    function automatic logic fp_is_zero(input float_t f);
        return f.exp == FP_ZERO_EXP;
    endfunction

endpackage

// File: rtl/horner_seq.sv
// Horner-rule polynomial sequencer driving an external multiply-add pipeline.
// Optional HORNER_TIMEOUT_EN adds o_err and a watchdog on the pipeline result.
module horner_seq
    import horner_pkg::*;
#(
    parameter int FRAC_WIDTH = FP_FRAC_W,
    parameter int EXP_WIDTH  = FP_EXP_W,
    parameter int NUM_COF    = 5,
    parameter int FMA_LAT    = 2,
    parameter int CIDX_W     = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_sign,
    input  logic [EXP_WIDTH-1:0]  i_req_exp,
    input  logic [FRAC_WIDTH-1:0] i_req_frac,
    input  logic                  i_req_flip,
    output logic [CIDX_W-1:0]     o_cof_idx,
    input  logic                  i_cof_sign,
    input  logic [EXP_WIDTH-1:0]  i_cof_exp,
    input  logic [FRAC_WIDTH-1:0] i_cof_frac,
    output logic                  o_fma_valid,
    output logic                  o_fma_m_sign,
    output logic [EXP_WIDTH-1:0]  o_fma_m_exp,
    output logic [FRAC_WIDTH-1:0] o_fma_m_frac,
    output logic                  o_fma_x_sign,
    output logic [EXP_WIDTH-1:0]  o_fma_x_exp,
    output logic [FRAC_WIDTH-1:0] o_fma_x_frac,
    output logic                  o_fma_c_sign,
    output logic [EXP_WIDTH-1:0]  o_fma_c_exp,
    output logic [FRAC_WIDTH-1:0] o_fma_c_frac,
    input  logic                  i_fma_valid,
    input  logic                  i_fma_sign,
    input  logic [EXP_WIDTH-1:0]  i_fma_exp,
    input  logic [FRAC_WIDTH-1:0] i_fma_frac,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic                  o_res_sign,
    output logic [EXP_WIDTH-1:0]  o_res_exp,
    output logic [FRAC_WIDTH-1:0] o_res_frac,
    output logic                  o_busy
`ifdef HORNER_TIMEOUT_EN
   ,output logic                  o_err
`endif
);

    localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(NUM_COF - 1);

    state_t             state_q, state_d;
    float_t             x_q, x_d;
    float_t             acc_q, acc_d;
    logic               flip_q, flip_d;
    logic [CIDX_W-1:0]  idx_q, idx_d;

    float_t             cof_w;
    float_t             fma_res_w;
    float_t             res_src_w;
    logic               x_zero_w;

    assign cof_w     = {i_cof_sign, i_cof_exp, i_cof_frac};
    assign fma_res_w = {i_fma_sign, i_fma_exp, i_fma_frac};
    assign x_zero_w  = fp_is_zero(x_q);

`ifdef HORNER_TIMEOUT_EN
    localparam int WCNT_W = $clog2(FMA_LAT + 3);
    localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(FMA_LAT + 2);

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;
`endif

    // k lives in idx_q: it is both the loop counter and the ROM address.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        flip_d  = flip_q;
        idx_d   = idx_q;
`ifdef HORNER_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    x_d     = {i_req_sign, i_req_exp, i_req_frac};
                    flip_d  = i_req_flip;
                    idx_d   = LAST_IDX;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                acc_d = cof_w;
                if (x_zero_w) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = LAST_IDX - 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef HORNER_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end
            ST_WAIT: begin
                if (i_fma_valid) begin
                    acc_d = fma_res_w;
                    if (idx_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
`ifdef HORNER_TIMEOUT_EN
                else if (wcnt_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                if (i_res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            flip_q  <= 1'b0;
            idx_q   <= '0;
`ifdef HORNER_TIMEOUT_EN
            wcnt_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            flip_q  <= flip_d;
            idx_q   <= idx_d;
`ifdef HORNER_TIMEOUT_EN
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
`endif
        end
    end

`ifdef HORNER_TIMEOUT_EN
    assign o_err = err_q;
`endif

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_cof_idx   = idx_q;
    assign o_fma_valid = (state_q == ST_ISSUE);

    assign o_fma_m_sign = acc_q.sign;
    assign o_fma_m_exp  = acc_q.exp;
    assign o_fma_m_frac = acc_q.frac;
    assign o_fma_x_sign = x_q.sign;
    assign o_fma_x_exp  = x_q.exp;
    assign o_fma_x_frac = x_q.frac;

    // The addend follows the ROM only while an iteration is in flight.
    always_comb begin
        if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
            o_fma_c_sign = cof_w.sign;
            o_fma_c_exp  = cof_w.exp;
            o_fma_c_frac = cof_w.frac;
        end else begin
            o_fma_c_sign = FP_ZERO.sign;
            o_fma_c_exp  = FP_ZERO.exp;
            o_fma_c_frac = FP_ZERO.frac;
        end
    end

    // A zero argument reduces p(x) to c0, which the ROM presents at index 0.
    assign res_src_w   = x_zero_w ? cof_w : acc_q;
    assign o_res_valid = (state_q == ST_DONE);

    always_comb begin
        if (state_q == ST_DONE) begin
            o_res_sign = res_src_w.sign ^ flip_q;
            o_res_exp  = res_src_w.exp;
            o_res_frac = res_src_w.frac;
        end else begin
            o_res_sign = FP_ZERO.sign;
            o_res_exp  = FP_ZERO.exp;
            o_res_frac = FP_ZERO.frac;
        end
    end

endmodule

// File: doc/horner_seq.md
Name: horner_seq

Overview:
- Sequencer that evaluates an NUM_COF-term polynomial p(x) = c0 + x·(c1 + x·(c2 + …)) by Horner's rule.
- Owns one fma3-style multiply-add pipeline of latency FMA_LAT and iterates it over coefficients fetched from an external coefficient ROM.
- Sits between the argument-reduction stage (request side) and the output formatter (result side) of the sincos datapath.

Parameters:
- FRAC_WIDTH, 40, mantissa width of all floating operands.
- EXP_WIDTH, 8, signed exponent width; exponent 8'h80 (most negative) encodes zero.
- NUM_COF, 5, number of coefficients (≥2).
- FMA_LAT, 2, issue-to-result latency of the multiply-add pipeline in cycles.
- CIDX_W, 3, coefficient index width, ≥ clog2(NUM_COF).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  sequencer can accept a request (high only in IDLE).
- i_req_sign / i_req_exp / i_req_frac  in  1/EXP_WIDTH/FRAC_WIDTH  argument x.
- i_req_flip  in  1  negate final result.
- o_cof_idx  out  CIDX_W  ROM address.
- i_cof_sign / i_cof_exp / i_cof_frac  in  1/EXP_WIDTH/FRAC_WIDTH  ROM data, combinational from o_cof_idx.
- o_fma_valid  out  1  issue strobe to the multiply-add pipeline.
- o_fma_m_sign/exp/frac  out  1/EXP_WIDTH/FRAC_WIDTH  multiplicand (accumulator).
- o_fma_x_sign/exp/frac  out  1/EXP_WIDTH/FRAC_WIDTH  multiplier (latched x).
- o_fma_c_sign/exp/frac  out  1/EXP_WIDTH/FRAC_WIDTH  addend (coefficient).
- i_fma_valid  in  1  result strobe from the pipeline.
- i_fma_sign/exp/frac  in  1/EXP_WIDTH/FRAC_WIDTH  pipeline result.
- o_res_valid  out  1  result held.
- i_res_ready  in  1  consumer accepts.
- o_res_sign/exp/frac  out  1/EXP_WIDTH/FRAC_WIDTH  p(x), sign XOR flip.
- o_busy  out  1  not IDLE.

Behaviour:
- Reset: FSM to IDLE; all outputs 0 except o_req_ready=1; o_fma_c_exp and o_res_exp = 8'h80 (zero encoding).
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE: on i_req_valid & o_req_ready, latch x and flip; set k = NUM_COF-1 and o_cof_idx = NUM_COF-1. Go to LOAD.
- LOAD: acc ← ROM[NUM_COF-1]. If x_exp == 8'h80 (x is zero), set o_cof_idx = 0 and go to DONE with result = ROM[0], no FMA issue. Otherwise set k = NUM_COF-2, o_cof_idx = k, and go to ISSUE.
- ISSUE: one-cycle o_fma_valid=1 with m=acc, x=latched x, c=ROM[k]. Go to WAIT.
- WAIT: hold o_fma_* stable, o_fma_valid=0. On i_fma_valid: acc ← result. If k==0, go to DONE; else k ← k-1, o_cof_idx ← k-1, go to ISSUE.
- i_fma_valid outside WAIT is ignored.
- Issue-to-result spacing is FMA_LAT cycles; total latency for nonzero x = 2 + (NUM_COF-1)·(FMA_LAT+1) cycles from acceptance to o_res_valid (14 at defaults).
- DONE: o_res_valid=1, result = {acc_sign ^ flip, acc_exp, acc_frac}, held stable until i_res_ready. The cycle after the handshake returns to IDLE; no back-to-back accept in the same cycle.
- Exactly NUM_COF-1 FMA issues per nonzero request, 0 for zero x.
- Reset asserted mid-operation aborts immediately. Any in-flight FMA result arriving after reset release is ignored (FSM is in IDLE).
- k and o_cof_idx never wrap below 0.

Optional Feature:
- HORNER_TIMEOUT_EN defined:
  - Adds output o_err (1 bit, reset 0) and an internal wait counter.
  - If WAIT lasts more than FMA_LAT+2 cycles without i_fma_valid, pulse o_err for one cycle and return to IDLE, dropping the request.
- Undefined: no counter, no o_err port, WAIT waits indefinitely.

Decomposition:
- Shared package horner_pkg:
  - float struct type {sign, exp, frac} sized by FRAC_WIDTH/EXP_WIDTH.
  - FP_ZERO_EXP = 8'h80.
  - FSM state enum.
- No sub-module; a single FSM plus datapath registers. The ROM is external.

Test Plan:
- Coefficients all 1.0, x=0.5, flip=0 → 4 issues, result 1.9375, o_res_valid 14 cycles after accept.
- x=0 (exp 8'h80), coefficients c0=0.75 → zero FMA issues, result 0.75, o_res_valid 2 cycles after accept.
- Same as first case with flip=1 → result −1.9375. Hold i_res_ready low 5 cycles → outputs stable, o_req_ready stays 0.
- i_req_valid held high through the DONE handshake → second request accepted only in the IDLE cycle after the handshake. Check o_cof_idx sequence 4,3,2,1,0 per request.
- Assert i_rst in the second WAIT → all outputs at reset values next cycle. A late i_fma_valid is ignored and no result is produced.
- HORNER_TIMEOUT_EN: withhold i_fma_valid → o_err pulses once 5 cycles into WAIT, FSM returns to IDLE, o_req_ready=1.
